// File: rtl/fetch_decode_stage_reg.sv
// IF/ID pipeline register: carries instruction, PC and PC+4 from fetch to decode
// with a valid/ready handshake, flush, and an optional two-entry skid buffer.
module fetch_decode_stage_reg #(
    parameter int unsigned     XLEN      = 32,
    parameter bit              SKID_EN   = 1'b1,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instruction_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_p_four_f,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] instruction_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_p_four_d,
    output logic [1:0]      occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    // Handshake: a beat moves on either side only on a clock edge where
    // valid && ready are both high; a valid source holds its data until then.
    logic [1:0]      state;
    logic [XLEN-1:0] m_instr, m_pc, m_pc4;
    logic [XLEN-1:0] s_instr, s_pc, s_pc4;
    logic            accept;
    logic            drain;

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = (state != ST_SKID);
        end else begin : g_noskid
            assign in_ready = (state == ST_EMPTY) || out_ready;
        end
    endgenerate

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign occupancy = state;

    // State is the occupancy count; with SKID_EN = 0 in_ready blocks the
    // FULL-without-drain accept, so ST_SKID is never reached.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state   <= ST_FULL;
                        m_instr <= instruction_f;
                        m_pc    <= pc_f;
                        m_pc4   <= pc_p_four_f;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        m_instr <= instruction_f;
                        m_pc    <= pc_f;
                        m_pc4   <= pc_p_four_f;
                    end else if (accept) begin
                        state   <= ST_SKID;
                        s_instr <= instruction_f;
                        s_pc    <= pc_f;
                        s_pc4   <= pc_p_four_f;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state   <= ST_FULL;
                        m_instr <= s_instr;
                        m_pc    <= s_pc;
                        m_pc4   <= s_pc4;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Invalid slots present a NOP and zero PCs so stale or X data never leaks.
    assign instruction_d = out_valid ? m_instr : NOP_INSTR;
    assign pc_d          = out_valid ? m_pc    : '0;
    assign pc_p_four_d   = out_valid ? m_pc4   : '0;

endmodule

// File: tb/tb_fetch_decode_stage_reg.sv
// Directed bench for fetch_decode_stage_reg: a default skid build (XLEN 32)
// and a single-entry build (XLEN 64) share clock and reset.
module tb_fetch_decode_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit skid instance
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction_f = '0, pc_f = '0, pc_p_four_f = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instruction_d, pc_d, pc_p_four_d;
    logic [1:0]  occupancy;

    // 64-bit single-entry instance
    logic        n_flush = 1'b0;
    logic        n_in_valid = 1'b0;
    logic        n_in_ready;
    logic [63:0] n_instruction_f = '0, n_pc_f = '0, n_pc_p_four_f = '0;
    logic        n_out_valid;
    logic        n_out_ready = 1'b0;
    logic [63:0] n_instruction_d, n_pc_d, n_pc_p_four_d;
    logic [1:0]  n_occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_decode_stage_reg u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_f(instruction_f), .pc_f(pc_f), .pc_p_four_f(pc_p_four_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction_d(instruction_d), .pc_d(pc_d), .pc_p_four_d(pc_p_four_d),
        .occupancy(occupancy)
    );

    fetch_decode_stage_reg #(
        .XLEN(64), .SKID_EN(1'b0), .NOP_INSTR(64'h0000_0000_0000_0013)
    ) u_dut64 (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .instruction_f(n_instruction_f), .pc_f(n_pc_f), .pc_p_four_f(n_pc_p_four_f),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .instruction_d(n_instruction_d), .pc_d(n_pc_d), .pc_p_four_d(n_pc_p_four_d),
        .occupancy(n_occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; registered outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid      = v;
        pc_f          = pc;
        pc_p_four_f   = pc + 32'd4;
        instruction_f = ins;
    endtask

    initial begin
        // reset for two edges
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_instr_nop", instruction_d, 32'h0000_0013);
        check("rst_pc", pc_d, 0);
        check("rst_pc4", pc_p_four_d, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst64_in_ready", n_in_ready, 1);
        check("rst64_instr_nop", n_instruction_d, 64'h13);
        rst = 1'b0;

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hAAAA_0001 + 32'(i));
            step();
            check("stream_valid", out_valid, 1);
            check("stream_occ", occupancy, 1);
            check("stream_pc", pc_d, 32'h100 + 32'(4 * i));
            check("stream_pc4", pc_p_four_d, 32'h104 + 32'(4 * i));
            check("stream_instr", instruction_d, 32'hAAAA_0001 + 32'(i));
        end
        drive(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        step();
        check("stream_empty", out_valid, 0);
        check("stream_x_pc", pc_d, 0);
        check("stream_x_instr", instruction_d, 32'h13);

        // backpressure fills the skid buffer
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hBBBB_0000);
        step();
        check("bp_occ1", occupancy, 1);
        check("bp_pc1", pc_d, 32'h200);
        drive(1'b1, 32'h204, 32'hBBBB_0004);
        step();
        check("bp_occ2", occupancy, 2);
        check("bp_in_ready0", in_ready, 0);
        check("bp_pc_hold", pc_d, 32'h200);
        drive(1'b1, 32'h208, 32'hBBBB_0008);
        step();
        check("bp_occ_still2", occupancy, 2);
        check("bp_pc_stable", pc_d, 32'h200);
        check("bp_instr_stable", instruction_d, 32'hBBBB_0000);
        out_ready = 1'b1;
        step();
        check("bp_drain_204", pc_d, 32'h204);
        check("bp_drain_instr", instruction_d, 32'hBBBB_0004);
        check("bp_occ_back1", occupancy, 1);
        check("bp_in_ready1", in_ready, 1);
        step();
        check("bp_drain_208", pc_d, 32'h208);
        check("bp_drain_valid", out_valid, 1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("bp_done_empty", occupancy, 0);

        // flush while the skid buffer is full
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'hCCCC_0000);
        step();
        drive(1'b1, 32'h504, 32'hCCCC_0004);
        step();
        check("fl_pre_occ2", occupancy, 2);
        flush = 1'b1;
        drive(1'b1, 32'h300, 32'hDDDD_0300);
        #1;
        check("fl_in_ready_same_cycle", in_ready, 0);
        step();
        check("fl_valid0", out_valid, 0);
        check("fl_occ0", occupancy, 0);
        check("fl_instr_nop", instruction_d, 32'h13);
        check("fl_pc0", pc_d, 0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("fl_300_dropped", out_valid, 0);

        // simultaneous accept and drain in FULL
        drive(1'b1, 32'h400, 32'hEEEE_0400);
        step();
        check("ad_pc400", pc_d, 32'h400);
        out_ready = 1'b1;
        drive(1'b1, 32'h404, 32'hEEEE_0404);
        step();
        check("ad_pc404", pc_d, 32'h404);
        check("ad_occ1", occupancy, 1);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h1);
        step();
        drive(1'b1, 32'h604, 32'h2);
        step();
        check("rs_pre_occ2", occupancy, 2);
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_occ0", occupancy, 0);
        check("rs_valid0", out_valid, 0);
        check("rs_in_ready1", in_ready, 1);

        // single-entry 64-bit build: combinational in_ready, wide values
        n_out_ready     = 1'b0;
        n_in_valid      = 1'b1;
        n_pc_f          = 64'hFFFF_FFFF_FFFF_FFFC;
        n_pc_p_four_f   = 64'h0;
        n_instruction_f = 64'hDEAD_BEEF_0123_4567;
        step();
        check("n_valid", n_out_valid, 1);
        check("n_pc_max", n_pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
        check("n_pc4_wrap", n_pc_p_four_d, 64'h0);
        check("n_instr", n_instruction_d, 64'hDEAD_BEEF_0123_4567);
        check("n_in_ready_stall", n_in_ready, 0);
        n_out_ready = 1'b1;
        #1;
        check("n_in_ready_comb", n_in_ready, 1);
        n_pc_f          = 64'h8000_0000_0000_0000;
        n_pc_p_four_f   = 64'h8000_0000_0000_0004;
        n_instruction_f = 64'h0000_0000_0000_0093;
        step();
        check("n_pass_pc", n_pc_d, 64'h8000_0000_0000_0000);
        check("n_pass_pc4", n_pc_p_four_d, 64'h8000_0000_0000_0004);
        check("n_occ1", n_occupancy, 1);
        n_pc_f = 64'h10;
        step();
        check("n_full_rate", n_pc_d, 64'h10);
        n_in_valid = 1'b0;
        step();
        check("n_empty", n_out_valid, 0);
        check("n_empty_pc", n_pc_d, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
